// File: rtl/isp_pkg.sv
// Shared ISP definitions: colour tags, gain helpers and rounding used by the pixel stages.
package isp_pkg;

    localparam int unsigned RED   = 0;
    localparam int unsigned GREEN = 1;
    localparam int unsigned BLUE  = 2;

    // Widest intermediate any stage feeds through the rounding helpers.
    localparam int unsigned MATH_W = 64;

    // Fixed-point representation of a gain of exactly 1.0.
    function automatic logic [31:0] gain_unity(input int unsigned frac_w);
        return 32'(1) << frac_w;
    endfunction

    // Round-half-up and drop frac_w fractional bits (frac_w must be at least 1).
    function automatic logic [MATH_W-1:0] round_shift(input logic [MATH_W-1:0] prod,
                                                      input int unsigned       frac_w);
        return (prod + (MATH_W'(1) << (frac_w - 1))) >> frac_w;
    endfunction

    // Round, then clip to the largest data_w-bit value.
    function automatic logic [MATH_W-1:0] sat_round(input logic [MATH_W-1:0] prod,
                                                    input int unsigned       frac_w,
                                                    input int unsigned       data_w);
        logic [MATH_W-1:0] r;
        logic [MATH_W-1:0] lim;
        r   = round_shift(prod, frac_w);
        lim = (MATH_W'(1) << data_w) - MATH_W'(1);
        return (r > lim) ? lim : r;
    endfunction

endpackage

// File: rtl/wb_mul_sat.sv
// Combinational pixel x gain multiply with round-half-up and clip to the pixel range.
module wb_mul_sat
    import isp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic [DATA_W-1:0] value,
    input  logic [GAIN_W-1:0] gain,
    output logic [DATA_W-1:0] res_c,
    output logic              sat_c
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W;

    logic [PROD_W-1:0] prod;
    logic [MATH_W-1:0] rnd;

    // Full-width product, rounded, then compared against the all-ones pixel.
    always_comb begin
        prod  = PROD_W'(value) * PROD_W'(gain);
        rnd   = round_shift(MATH_W'(prod), FRAC_W);
        sat_c = (rnd > MATH_W'({DATA_W{1'b1}}));
        res_c = sat_c ? {DATA_W{1'b1}} : rnd[DATA_W-1:0];
    end

endmodule

// File: rtl/wb_gain_stage.sv
// White-balance gain stage: per-channel gains, two-stage elastic pipeline,
// frame-aligned gain commit and per-frame saturated-pixel count.
module wb_gain_stage
    import isp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned N_CH   = 3,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_color,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_last,
    input  logic              bypass,
    input  logic              gain_we,
    input  logic [CH_W-1:0]   gain_ch,
    input  logic [GAIN_W-1:0] gain_wdata,
    input  logic              gain_commit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_color,
    output logic [DATA_W-1:0] out_value,
    output logic              out_last,
    output logic [CNT_W-1:0]  sat_frame
);

    localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(gain_unity(FRAC_W));
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_FRAME_PEND
    } commit_state_t;

    commit_state_t     state, state_nxt;
    logic              in_frame, pend_eff, copy, frame_nxt, pend_nxt;
    logic              rdy, adv, xfer_in;
    logic [GAIN_W-1:0] shadow     [N_CH];
    logic [GAIN_W-1:0] shadow_nxt [N_CH];
    logic [GAIN_W-1:0] active     [N_CH];
    logic [GAIN_W-1:0] sel_gain;
    logic              sel_known;

    logic              s1_valid, s1_last, s1_pass;
    logic [CH_W-1:0]   s1_color;
    logic [DATA_W-1:0] s1_value;
    logic [GAIN_W-1:0] s1_gain;
    logic [DATA_W-1:0] mul_res;
    logic              mul_sat;
    logic              out_sat;
    logic [CNT_W-1:0]  sat_cnt;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = rdy & adv;
    assign xfer_in  = in_valid & in_ready;

    // Active gain for the incoming tag; unknown tags are flagged for pass-through.
    always_comb begin
        sel_gain  = UNITY;
        sel_known = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (in_color == CH_W'(i)) begin
                sel_gain  = active[i];
                sel_known = 1'b1;
            end
        end
    end

    // Shadow bank after this cycle's write; out-of-range channels never match.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            shadow_nxt[i] = (gain_we && gain_ch == CH_W'(i)) ? gain_wdata : shadow[i];
        end
    end

    // Commit FSM: tracks frame position and a pending commit, fires the bank copy.
    always_comb begin
        state_nxt = state;
        in_frame  = (state != ST_IDLE);
        pend_eff  = (state == ST_FRAME_PEND) | gain_commit;
        copy      = pend_eff & ((~in_frame & ~xfer_in) | (xfer_in & in_last));
        frame_nxt = xfer_in ? ~in_last : in_frame;
        pend_nxt  = pend_eff & ~copy;
        if (!frame_nxt) begin
            state_nxt = ST_IDLE;
        end else if (pend_nxt) begin
            state_nxt = ST_FRAME_PEND;
        end else begin
            state_nxt = ST_FRAME;
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Gain banks: shadow follows writes, active copies shadow on a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                shadow[i] <= UNITY;
                active[i] <= UNITY;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (copy) active[i] <= shadow_nxt[i];
            end
        end
    end

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy <= 1'b0;
        else        rdy <= 1'b1;
    end

    // S1: capture pixel, tag, last and the gain it will be multiplied by.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pass  <= 1'b0;
            s1_color <= '0;
            s1_value <= '0;
            s1_gain  <= '0;
        end else if (adv) begin
            s1_valid <= xfer_in;
            s1_last  <= in_last;
            s1_pass  <= bypass | ~sel_known;
            s1_color <= in_color;
            s1_value <= in_value;
            s1_gain  <= sel_gain;
        end
    end

    wb_mul_sat #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .value (s1_value),
        .gain  (s1_gain),
        .res_c (mul_res),
        .sat_c (mul_sat)
    );

    // S2: register the gained (or passed-through) result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_color <= '0;
            out_value <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_last  <= s1_last;
            out_color <= s1_color;
            out_value <= s1_pass ? s1_value : mul_res;
            out_sat   <= s1_pass ? 1'b0 : mul_sat;
        end
    end

    // Saturated-pixel counter, published and cleared when a frame's last pixel leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt   <= '0;
            sat_frame <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                sat_frame <= (out_sat && sat_cnt != CNT_MAX) ? sat_cnt + CNT_W'(1) : sat_cnt;
                sat_cnt   <= '0;
            end else if (out_sat && sat_cnt != CNT_MAX) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_gain_stage.sv
// Self-checking bench for wb_gain_stage: vector table, hand sequences, random back-pressure run.
module tb_wb_gain_stage;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned GAIN_W = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned N_CH   = 3;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CNT_W  = 20;

    logic              clk, rst_n;
    logic              in_valid, in_ready, in_last, bypass;
    logic [CH_W-1:0]   in_color;
    logic [DATA_W-1:0] in_value;
    logic              gain_we, gain_commit;
    logic [CH_W-1:0]   gain_ch;
    logic [GAIN_W-1:0] gain_wdata;
    logic              out_valid, out_ready, out_last;
    logic [CH_W-1:0]   out_color;
    logic [DATA_W-1:0] out_value;
    logic [CNT_W-1:0]  sat_frame;

    wb_gain_stage #(
        .DATA_W (DATA_W), .GAIN_W (GAIN_W), .FRAC_W (FRAC_W),
        .N_CH   (N_CH),   .CH_W   (CH_W),   .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_color    (in_color),
        .in_value    (in_value),
        .in_last     (in_last),
        .bypass      (bypass),
        .gain_we     (gain_we),
        .gain_ch     (gain_ch),
        .gain_wdata  (gain_wdata),
        .gain_commit (gain_commit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_color   (out_color),
        .out_value   (out_value),
        .out_last    (out_last),
        .sat_frame   (sat_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model state (expressed as the specified frame/commit rules).
    typedef struct {
        int value;
        int color;
        bit last;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   m_shadow [3];
    int   m_active [3];
    bit   m_pend, m_in_frame;
    int   m_cnt, exp_sf;
    bit   xfer;
    bit   was_stall;
    int   h_value, h_color;
    bit   h_last;

    function automatic void ref_pix(input int v, input int c, input int g, input bit byp,
                                    output int r, output bit s);
        longint p;
        if (byp || c >= 3) begin
            r = v;
            s = 1'b0;
        end else begin
            p = (longint'(v) * longint'(g) + 128) / 256;
            if (p > 255) begin
                r = 255;
                s = 1'b1;
            end else begin
                r = int'(p);
                s = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            m_shadow[i] = 256;
            m_active[i] = 256;
        end
        m_pend     = 1'b0;
        m_in_frame = 1'b0;
        m_cnt      = 0;
        exp_sf     = 0;
        was_stall  = 1'b0;
    endfunction

    // One clock: check outputs, advance the model, cross the edge, return at the falling edge.
    task automatic step();
        exp_t e;
        int   r, g, c, sf_new;
        bit   s, pe, cp;
        int   sh [3];
        #1;
        xfer   = in_valid && in_ready;
        sf_new = exp_sf;
        check("sat_frame", sat_frame, exp_sf);
        if (was_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_value", out_value, h_value);
            check("stall_color", out_color, h_color);
            check("stall_last",  out_last,  h_last);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_value", out_value, e.value);
                check("out_color", out_color, e.color);
                check("out_last",  out_last,  e.last);
                obs_q.push_back(int'(out_value));
                if (e.last) begin
                    sf_new = m_cnt + int'(e.sat);
                    m_cnt  = 0;
                end else begin
                    m_cnt = m_cnt + int'(e.sat);
                end
            end
        end
        was_stall = out_valid && !out_ready;
        h_value   = int'(out_value);
        h_color   = int'(out_color);
        h_last    = out_last;
        c = int'(in_color);
        if (xfer) begin
            g = (c < 3) ? m_active[c] : 0;
            ref_pix(int'(in_value), c, g, bypass, r, s);
            e.value = r; e.color = c; e.last = in_last; e.sat = s;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 3; i++) sh[i] = m_shadow[i];
        if (gain_we && int'(gain_ch) < 3) sh[int'(gain_ch)] = int'(gain_wdata);
        pe = m_pend || gain_commit;
        cp = pe && ((!m_in_frame && !xfer) || (xfer && in_last));
        if (cp) for (int i = 0; i < 3; i++) m_active[i] = sh[i];
        for (int i = 0; i < 3; i++) m_shadow[i] = sh[i];
        m_pend = pe && !cp;
        if (xfer) m_in_frame = !in_last;
        @(posedge clk);
        @(negedge clk);
        exp_sf = sf_new;
    endtask

    task automatic set_gain(input int ch, input int g);
        gain_we     = 1'b1;
        gain_ch     = CH_W'(ch);
        gain_wdata  = GAIN_W'(g);
        gain_commit = 1'b1;
        step();
        gain_we     = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic send_pixel(input int c, input int v, input bit last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_color = CH_W'(c);
        in_value = DATA_W'(v);
        in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = xfer;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    typedef struct {
        bit byp;
        int color;
        int value;
        int gain;
        int exp_value;
        int exp_sat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int accepted;
        int cycles;

        tbl[0]  = '{0, 0, 0,   256,   0,   0};
        tbl[1]  = '{0, 1, 1,   256,   1,   0};
        tbl[2]  = '{0, 2, 128, 256,   128, 0};
        tbl[3]  = '{0, 0, 255, 256,   255, 0};
        tbl[4]  = '{0, 0, 100, 384,   150, 0};
        tbl[5]  = '{0, 0, 200, 384,   255, 1};
        tbl[6]  = '{0, 1, 3,   128,   2,   0};
        tbl[7]  = '{0, 1, 1,   128,   1,   0};
        tbl[8]  = '{0, 2, 77,  0,     0,   0};
        tbl[9]  = '{0, 3, 200, 384,   200, 0};
        tbl[10] = '{1, 0, 200, 384,   200, 0};
        tbl[11] = '{0, 2, 255, 65535, 255, 1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_color    = '0;
        in_value    = '0;
        in_last     = 1'b0;
        bypass      = 1'b0;
        gain_we     = 1'b0;
        gain_ch     = '0;
        gain_wdata  = '0;
        gain_commit = 1'b0;
        out_ready   = 1'b1;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_sat_frame", sat_frame, 0);
        check("rst_out_value", out_value, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", in_ready, 1);
        @(negedge clk);

        // Single-pixel frames from the vector table.
        foreach (tbl[k]) begin
            bypass = tbl[k].byp;
            set_gain(tbl[k].color, tbl[k].gain);
            obs_q.delete();
            send_pixel(tbl[k].color, tbl[k].value, 1'b1);
            drain();
            check($sformatf("tbl%0d_count", k), obs_q.size(), 1);
            if (obs_q.size() == 1) check($sformatf("tbl%0d_value", k), obs_q[0], tbl[k].exp_value);
            check($sformatf("tbl%0d_sat", k), sat_frame, tbl[k].exp_sat);
            bypass = 1'b0;
        end

        // Three clipped RED pixels in one frame.
        set_gain(0, 384);
        send_pixel(0, 200, 1'b0);
        send_pixel(0, 200, 1'b0);
        send_pixel(0, 200, 1'b1);
        drain();
        check("sat_frame_three", sat_frame, 3);

        // Mid-frame GREEN write+commit lands only on the next frame.
        set_gain(1, 256);
        obs_q.delete();
        send_pixel(1, 60, 1'b0);
        gain_we = 1'b1; gain_ch = CH_W'(1); gain_wdata = GAIN_W'(16'h0200); gain_commit = 1'b1;
        step();
        gain_we = 1'b0; gain_commit = 1'b0;
        send_pixel(1, 60, 1'b1);
        send_pixel(1, 60, 1'b1);
        drain();
        check("midframe_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("midframe_px0", obs_q[0], 60);
            check("midframe_px1", obs_q[1], 60);
            check("midframe_px2", obs_q[2], 120);
        end

        // Random traffic with random back-pressure and gain updates.
        accepted = 0;
        cycles   = 0;
        obs_q.delete();
        while (accepted < 1000 && cycles < 20000) begin
            if (!in_valid || xfer) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_color = CH_W'($urandom_range(0, 3));
                in_value = DATA_W'($urandom_range(0, 255));
                in_last  = ($urandom_range(0, 15) == 0);
            end
            out_ready   = $urandom_range(0, 1) == 1;
            gain_we     = ($urandom_range(0, 39) == 0);
            gain_ch     = CH_W'($urandom_range(0, 3));
            gain_wdata  = GAIN_W'($urandom_range(0, 1023));
            gain_commit = ($urandom_range(0, 59) == 0);
            step();
            if (xfer) accepted++;
            cycles++;
        end
        check("random_accepted", accepted, 1000);
        in_valid = 1'b0; in_last = 1'b0; gain_we = 1'b0; gain_commit = 1'b0;
        out_ready = 1'b1;
        drain();
        check("random_outputs", obs_q.size(), 1000);

        // Reset in the middle of a stalled frame.
        set_gain(0, 256);
        send_pixel(0, 250, 1'b1);
        drain();
        set_gain(0, 384);
        send_pixel(0, 200, 1'b1);
        drain();
        check("pre_reset_sat_frame", sat_frame, 1);
        out_ready = 1'b0;
        send_pixel(0, 10, 1'b0);
        send_pixel(0, 20, 1'b0);
        step();
        check("pre_reset_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_frame", sat_frame, 0);
        check("midrst_in_ready",  in_ready,  0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        obs_q.delete();
        send_pixel(0, 100, 1'b1);
        drain();
        check("post_reset_count", obs_q.size(), 1);
        if (obs_q.size() == 1) check("post_reset_unity", obs_q[0], 100);
        check("post_reset_sat_frame", sat_frame, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
